// File: rtl/operand_conditioner_pkg.sv
// Shared processor constants: ALU opcodes and operand-conditioner mode encodings.
// Imported by the operand conditioner and any datapath block that issues modes to it.
package operand_conditioner_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SHL  = 4'h5,
    ALU_SHR  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_PASS = 4'h8
  } alu_op_e;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_PASS = 2'b00,
    MODE_NEG  = 2'b01,
    MODE_INV  = 2'b10,
    MODE_ABS  = 2'b11
  } cond_mode_e;

endpackage

// File: rtl/cond_fifo.sv
// Result buffer for the operand conditioner: FIFO with asynchronous reset,
// synchronous flush and an asynchronously read head so results appear one cycle after write.
module cond_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  // Flush and reset both override any same-cycle push or pop.
  assign do_push = push && !full && !flush && !reset;
  assign do_pop  = pop && !empty && !flush && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign head  = mem[rd_ptr_reg];
  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/operand_conditioner.sv
// Operand conditioner: pass / negate / invert / absolute with optional saturation,
// results queued in a small FIFO with valid/ready handshakes on both sides.
module operand_conditioner
  import operand_conditioner_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [MODE_W-1:0]      in_mode,
  input  logic                   sat_en,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_ovf,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

  cond_mode_e       mode;
  logic [WIDTH-1:0] neg_val;
  logic             is_most_neg;
  logic [WIDTH-1:0] result;
  logic             result_ovf;
  logic             full;
  logic             empty;
  logic             accept;
  logic             pop;
  logic [WIDTH:0]   head;

  assign mode        = cond_mode_e'(in_mode);
  assign neg_val     = ~in_data + WIDTH'(1);
  assign is_most_neg = (in_data == MOST_NEG);

  always_comb begin
    result     = in_data;
    result_ovf = 1'b0;
    case (mode)
      MODE_PASS: result = in_data;
      MODE_INV:  result = ~in_data;
      MODE_NEG, MODE_ABS: begin
        if (mode == MODE_ABS && !in_data[WIDTH-1]) begin
          result = in_data;
        end else if (is_most_neg) begin
          // The negation of the most negative value is unrepresentable.
          result_ovf = 1'b1;
          result     = sat_en ? MOST_POS : in_data;
        end else begin
          result = neg_val;
        end
      end
      default: result = in_data;
    endcase
  end

  assign in_ready  = !reset && !flush && !full;
  assign accept    = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  cond_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (accept),
    .push_data ({result_ovf, result}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Forcing zero when empty keeps outputs clean during and right after reset.
  assign out_data = out_valid ? head[WIDTH-1:0] : '0;
  assign out_ovf  = out_valid & head[WIDTH];

endmodule
